// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared control-path types and constants for the RV32I core.
package riscv_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam int REG_W = 5;
    localparam int NREGS = 32;

    // Major opcodes, shared with the decoder.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Decoder helpers: which opcodes touch data memory or may change the PC.
    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_ctrl_op(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_reg_scoreboard.sv
// Per-register pending-write scoreboard: 2-bit counters, x0 never tracked,
// with a same-cycle WB-to-ID bypass on the busy queries.
module reg_scoreboard
    import riscv_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_en,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             retire_en,
    input  logic [REG_W-1:0] retire_rd,
    input  logic [REG_W-1:0] query_rs1,
    input  logic [REG_W-1:0] query_rs2,
    output logic             busy_rs1,
    output logic             busy_rs2
);

    logic [1:0] cnt_q [NREGS];
    logic [1:0] cnt_d [NREGS];

    logic do_issue;
    logic do_retire;
    logic same_reg;

    assign do_issue  = issue_en  && (issue_rd  != '0);
    assign do_retire = retire_en && (retire_rd != '0);
    assign same_reg  = do_issue && do_retire && (issue_rd == retire_rd);

    // Next count per register: issue increments, retire decrements, both cancel; saturate at the ends.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!same_reg) begin
                if (do_issue && (issue_rd == REG_W'(i)) && (cnt_q[i] != 2'd3)) begin
                    cnt_d[i] = cnt_q[i] + 2'd1;
                end else if (do_retire && (retire_rd == REG_W'(i)) && (cnt_q[i] != 2'd0)) begin
                    cnt_d[i] = cnt_q[i] - 2'd1;
                end
            end
        end
    end

    // Counter array register.
    always_ff @(posedge clk) begin
        // NOTE: the counters are real state, not a RAM: every entry must clear on reset or stale pending writes would stall forever.
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A register is busy when it has a pending write that is not retiring this very cycle.
    assign busy_rs1 = (query_rs1 != '0) &&
                      (cnt_q[query_rs1] > {1'b0, do_retire && (retire_rd == query_rs1)});
    assign busy_rs2 = (query_rs2 != '0) &&
                      (cnt_q[query_rs2] > {1'b0, do_retire && (retire_rd == query_rs2)});

    // Counter range checks: more than three writes in flight, or a retire with nothing pending.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(do_issue && !same_reg && (cnt_q[issue_rd] == 2'd3)));
            assert (!(do_retire && !same_reg && (cnt_q[retire_rd] == 2'd0)));
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait FSM with
// timeout, redirect flushing and data-hazard bubble insertion.
module pipeline_hazard_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter bit FORWARDING  = 1'b1,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_write,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_load,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             wb_write,
    input  logic [REG_W-1:0] wb_rd,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_if,
    output logic             flush_id,
    output logic             freeze,
    output logic             mem_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;

    logic load_use;
    logic busy_rs1, busy_rs2;
    logic hazard;

    // Freeze depends only on state and the memory handshake, so the scoreboard bypass can use it loop-free.
    assign freeze  = !reset && ((state_q == MEM_WAIT) || (dmem_req && !dmem_ready));
    assign mem_err = !reset && mem_err_q;

    assign load_use = ex_valid && ex_load && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    reg_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .issue_en  (id_valid && id_write && !stall_id && !flush_id && !freeze),
        .issue_rd  (id_rd),
        .retire_en (wb_write && !freeze),
        .retire_rd (wb_rd),
        .query_rs1 (id_rs1),
        .query_rs2 (id_rs2),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2)
    );

    assign hazard = FORWARDING ? load_use : (busy_rs1 || busy_rs2);

    // Next state, timeout counting and the freeze > redirect > hazard output priority.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a value held, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;

        if (reset) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state_d = MEM_WAIT;
                        cnt_d   = CNT_W'(1);   // the entry cycle is the first frozen cycle
                    end else if (ex_redirect) begin
                        flush_if = 1'b1;
                        flush_id = 1'b1;
                    end else if (hazard) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_id = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_d = RUN;
                    end else if ((MEM_TIMEOUT != 0) && (cnt_q >= CNT_LAST)) begin
                        mem_err_d = 1'b1;
                        state_d   = RUN;
                    end else if (MEM_TIMEOUT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State, timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

endmodule
